// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU internal data bus (IDB): arbiter state encoding
// and default bus sizing.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int IDB_W        = 16;
  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/cpu_rr_pick.sv
// Combinational round-robin search: first requesting index after last_i,
// wrapping from N_REQ-1 to 0; last_i itself is considered last.
module cpu_rr_pick
  import cpu_bus_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OW-1:0]    last_i,
  output logic             found_o,
  output logic [OW-1:0]    idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = last_i;
    for (int k = 1; k <= N_REQ; k++) begin
      int cand;
      cand = int'(last_i) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = OW'(cand);
      end
    end
  end

endmodule

// File: rtl/cpu_idb_arb.sv
// IDB arbiter: round-robin grant with per-tenure hold limit and a one-cycle
// turnaround between drivers; grant registered one cycle after request.
module cpu_idb_arb
  import cpu_bus_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IDB_W    = cpu_bus_pkg::IDB_W,
  parameter int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   sysclk,
  input  logic                   sys_rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       rel,
  input  logic [N_REQ*IDB_W-1:0] drv_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [OW-1:0]          owner,
  output logic [IDB_W-1:0]       idb_out,
  output logic                   idb_valid,
  output logic                   tmo_err
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e       state_q;
  logic [OW-1:0]    owner_q;
  logic [N_REQ-1:0] gnt_q;
  logic [HW-1:0]    hold_q;
  logic             tmo_q;

  logic             found;
  logic [OW-1:0]    pick;
  logic [N_REQ-1:0] pick_oh;
  logic             expire_d;
  logic             drop_d;

  cpu_rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
    .req_i   (req),
    .last_i  (owner_q),
    .found_o (found),
    .idx_o   (pick)
  );

  assign pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
  assign expire_d = (hold_q == HW'(MAX_HOLD - 1));
  assign drop_d   = rel[owner_q] | ~req[owner_q];

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      owner_q <= OW'(N_REQ - 1);
      gnt_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, TURN: begin
          tmo_q <= 1'b0;
          if (found) begin
            state_q <= GRANT;
            owner_q <= pick;
            gnt_q   <= pick_oh;
            hold_q  <= '0;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end
        end
        GRANT: begin
          if (drop_d || expire_d) begin
            state_q <= TURN;
            gnt_q   <= '0;
            // Timeout only when the owner still wanted the bus.
            tmo_q   <= expire_d & ~drop_d;
          end else begin
            hold_q  <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          tmo_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    idb_out = '0;
    if (state_q == GRANT) idb_out = drv_data[owner_q*IDB_W +: IDB_W];
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign idb_valid = |gnt_q;
  assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_cpu_idb_arb.sv
// Directed bench for cpu_idb_arb with hand-computed expectations.
module tb_cpu_idb_arb;

  logic        sysclk;
  logic        sys_rst;
  logic [3:0]  req;
  logic [3:0]  rel;
  logic [63:0] drv_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [15:0] idb_out;
  logic        idb_valid;
  logic        tmo_err;

  int tests_run;
  int tests_failed;

  cpu_idb_arb dut (
    .sysclk    (sysclk),
    .sys_rst   (sys_rst),
    .req       (req),
    .rel       (rel),
    .drv_data  (drv_data),
    .gnt       (gnt),
    .owner     (owner),
    .idb_out   (idb_out),
    .idb_valid (idb_valid),
    .tmo_err   (tmo_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req     = '0;
    rel     = '0;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  initial begin
    int order [5];
    tests_run    = 0;
    tests_failed = 0;
    order        = '{0, 1, 2, 3, 0};
    drv_data     = {16'hD333, 16'hC222, 16'hB111, 16'hA000};

    do_reset();
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h3);
    chk("rst_valid", 32'(idb_valid), 32'h0);
    chk("rst_out",   32'(idb_out), 32'h0);
    chk("rst_tmo",   32'(tmo_err), 32'h0);

    // single requester 0
    req = 4'b0001;
    step();
    chk("r0_gnt",   32'(gnt), 32'h1);
    chk("r0_out",   32'(idb_out), 32'hA000);
    chk("r0_valid", 32'(idb_valid), 32'h1);
    chk("r0_owner", 32'(owner), 32'h0);
    req = 4'b0000;
    step();
    chk("r0_turn_gnt",   32'(gnt), 32'h0);
    chk("r0_turn_valid", 32'(idb_valid), 32'h0);
    chk("r0_turn_out",   32'(idb_out), 32'h0);
    step();
    chk("r0_idle_gnt", 32'(gnt), 32'h0);
    chk("r0_idle_owner", 32'(owner), 32'h0);

    // round robin, all requesting, release on 2nd grant cycle
    do_reset();
    req = 4'b1111;
    step();
    for (int t = 0; t < 5; t++) begin
      chk("rr_c1_gnt", 32'(gnt), 32'(4'b0001 << order[t]));
      chk("rr_c1_out", 32'(idb_out), 32'(drv_data[order[t]*16 +: 16]));
      step();
      chk("rr_c2_gnt", 32'(gnt), 32'(4'b0001 << order[t]));
      rel = 4'b0001 << order[t];
      step();
      rel = 4'b0000;
      chk("rr_turn_gnt", 32'(gnt), 32'h0);
      chk("rr_turn_valid", 32'(idb_valid), 32'h0);
      if (t == 4) req = 4'b0000;
      step();
    end
    chk("rr_idle_gnt", 32'(gnt), 32'h0);

    // MMU holds without release: 16 grant cycles then timeout
    req = 4'b0100;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_hold_gnt", 32'(gnt), 32'h4);
      chk("tmo_hold_err", 32'(tmo_err), 32'h0);
      step();
    end
    chk("tmo_turn_gnt", 32'(gnt), 32'h0);
    chk("tmo_pulse",    32'(tmo_err), 32'h1);
    step();
    chk("tmo_regrant",  32'(gnt), 32'h4);
    chk("tmo_cleared",  32'(tmo_err), 32'h0);
    req = 4'b0000;
    step();
    chk("drop_no_tmo",  32'(tmo_err), 32'h0);
    step();

    // owner 2 drops req while 3 waits; stray rel[1] ignored
    req = 4'b0100;
    step();
    chk("d2_gnt", 32'(gnt), 32'h4);
    req = 4'b1100;
    rel = 4'b0010;
    step();
    rel = 4'b0000;
    chk("d2_rel1_ignored", 32'(gnt), 32'h4);
    req = 4'b1000;
    step();
    chk("d2_turn", 32'(gnt), 32'h0);
    step();
    chk("d3_gnt",   32'(gnt), 32'h8);
    chk("d3_owner", 32'(owner), 32'h3);
    chk("d3_out",   32'(idb_out), 32'hD333);

    // reset mid-grant of owner 3
    sys_rst = 1'b1;
    step();
    chk("mrst_gnt",   32'(gnt), 32'h0);
    chk("mrst_owner", 32'(owner), 32'h3);
    chk("mrst_tmo",   32'(tmo_err), 32'h0);
    chk("mrst_valid", 32'(idb_valid), 32'h0);
    sys_rst = 1'b0;
    req     = 4'b1001;
    step();
    chk("mrst_first", 32'(gnt), 32'h1);
    chk("mrst_out",   32'(idb_out), 32'hA000);
    rel = 4'b0001;
    step();
    rel = 4'b0000;
    chk("mrst_turn", 32'(gnt), 32'h0);
    step();
    chk("fair_next", 32'(gnt), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
